// File: rtl/hdb3_if.sv
// HDB3 receive bus: symbol strobe and rails in, decoded NRZ and error status out.
// No backpressure; the consumer must take data_out whenever data_valid pulses.
interface hdb3_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 en;
  logic                 bp;
  logic                 bn;
  logic                 err_clr;
  logic                 data_out;
  logic                 data_valid;
  logic                 code_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output en, bp, bn, err_clr,
    input  data_out, data_valid, code_err, err_cnt
  );

  modport slave (
    input  en, bp, bn, err_clr,
    output data_out, data_valid, code_err, err_cnt
  );
endinterface

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: strips 000V/B00V, flags code violations; bit n leaves one cycle after symbol n+3.
// No backpressure: en paces symbols, outputs are single-cycle pulses.
module hdb3_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  hdb3_if.slave  bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [3:1]           sr;
  logic [1:0]           fill;
  logic [2:0]           zrun;
  logic                 have_mark;
  logic                 last_pol;
  logic                 have_v;
  logic                 last_v_pol;
  logic                 data_q;
  logic                 valid_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  logic illegal;
  logic mark;
  logic pol;
  logic is_v;
  logic evict;
  logic bad_pos;
  logic bad_pol;
  logic zrun_hit;
  logic sym_err;

  always_comb begin
    illegal  = bus.bp & bus.bn;
    mark     = bus.bp ^ bus.bn;
    pol      = bus.bn;
    is_v     = mark & have_mark & (pol == last_pol);
    // A V cancels the pulse at V-3 (B of B00V, or a plain zero of 000V)
    evict    = is_v ? 1'b0 : sr[3];
    bad_pos  = is_v & (sr[1] | sr[2]);
    bad_pol  = is_v & have_v & (pol == last_v_pol);
    zrun_hit = ~mark & (zrun == 3'd3);
    sym_err  = illegal | bad_pos | bad_pol | zrun_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= 3'b000;
      fill       <= 2'd0;
      zrun       <= 3'd0;
      have_mark  <= 1'b0;
      last_pol   <= 1'b0;
      have_v     <= 1'b0;
      last_v_pol <= 1'b0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.en) begin
        sr    <= {sr[2], sr[1], mark & ~is_v};
        err_q <= sym_err;
        if (fill == 2'd3) begin
          data_q  <= evict;
          valid_q <= 1'b1;
        end else begin
          fill <= fill + 2'd1;
        end
        if (mark) begin
          have_mark <= 1'b1;
          last_pol  <= pol;
          zrun      <= 3'd0;
        end else if (zrun != 3'd4) begin
          zrun <= zrun + 3'd1;
        end
        if (is_v) begin
          have_v     <= 1'b1;
          last_v_pol <= pol;
        end
      end
    end
  end

  // Clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.err_clr) begin
      cnt_q <= '0;
    end else if (bus.en && sym_err && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.code_err   = err_q;
  assign bus.err_cnt    = cnt_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Randomized and directed checks of hdb3_decoder against an array-based HDB3 reference model.
module tb_hdb3_decoder;
  localparam int W       = 8;
  localparam int CNT_MAX = (1 << W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   err_pulses;

  hdb3_if #(.ERR_CNT_W(W)) bus ();

  hdb3_decoder #(.ERR_CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decoded stream since reset, with V pulses removed and
  // the symbol three places before each V cancelled.
  bit dec[$];
  bit have_mark, last_pol, have_v, last_v_pol;
  int zeros;
  int cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    dec.delete();
    have_mark  = 0;
    last_pol   = 0;
    have_v     = 0;
    last_v_pol = 0;
    zeros      = 0;
    cnt        = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      bus.en      = $urandom_range(0, 1);
      bus.bp      = $urandom_range(0, 1);
      bus.bn      = $urandom_range(0, 1);
      bus.err_clr = 1'b0;
      @(posedge clk);
      #1;
      check("rst_data_out",   bus.data_out,   0);
      check("rst_data_valid", bus.data_valid, 0);
      check("rst_code_err",   bus.code_err,   0);
      check("rst_err_cnt",    bus.err_cnt,    0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit e, input bit p, input bit n, input bit clr);
    int  k;
    bit  mark, is_v, err, exp_vld, exp_dat;
    exp_vld = 0;
    exp_dat = 0;
    err     = 0;
    if (e) begin
      k    = dec.size();
      mark = p ^ n;
      is_v = mark && have_mark && (n == last_pol);
      if (p && n) err = 1;
      if (is_v) begin
        if (k >= 1 && dec[k-1]) err = 1;
        if (k >= 2 && dec[k-2]) err = 1;
        if (have_v && n == last_v_pol) err = 1;
        have_v     = 1;
        last_v_pol = n;
        if (k >= 3) dec[k-3] = 0;
      end
      if (mark) begin
        have_mark = 1;
        last_pol  = n;
        zeros     = 0;
      end else begin
        zeros++;
        if (zeros == 4) err = 1;
      end
      dec.push_back(mark && !is_v);
      if (k >= 3) begin
        exp_vld = 1;
        exp_dat = dec[k-3];
      end
    end
    if (clr) cnt = 0;
    else if (e && err && cnt < CNT_MAX) cnt++;

    bus.en      = e;
    bus.bp      = p;
    bus.bn      = n;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    check("data_valid", bus.data_valid, exp_vld);
    check("code_err",   bus.code_err,   e && err);
    check("err_cnt",    bus.err_cnt,    cnt);
    if (exp_vld) check("data_out", bus.data_out, exp_dat);
    if (bus.code_err) err_pulses++;
  endtask

  // Symbol helpers: +1 positive, -1 negative, 0 space, 2 illegal
  task automatic sym(input int s);
    case (s)
      1:       drive(1, 1, 0, 0);
      -1:      drive(1, 0, 1, 0);
      2:       drive(1, 1, 1, 0);
      default: drive(1, 0, 0, 0);
    endcase
  endtask

  int ami[]  = '{1, 0, -1, 1, 0, 0, -1, 1, -1, 1};
  int subs[] = '{1, 0, 0, 0, 1, -1, 0, 0, -1, 1, 0, 0, 1, -1, 1, -1};
  int ill[]  = '{1, -1, 2, 1, -1, 1, -1};

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    err_pulses  = 0;
    bus.en      = 1'b0;
    bus.bp      = 1'b0;
    bus.bn      = 1'b0;
    bus.err_clr = 1'b0;
    rst_n       = 1'b0;
    model_reset();

    do_reset(4);
    sym(1);
    check("first_mark_not_v", bus.code_err, 0);
    foreach (ami[i]) sym(ami[i]);

    do_reset(2);
    foreach (subs[i]) sym(subs[i]);

    do_reset(2);
    foreach (ill[i]) sym(ill[i]);
    check("illegal_cnt", bus.err_cnt, 1);

    do_reset(2);
    err_pulses = 0;
    sym(1);
    for (int i = 0; i < 6; i++) sym(0);
    check("zrun_pulses", err_pulses, 1);
    check("zrun_cnt", bus.err_cnt, 1);

    do_reset(2);
    sym(1);
    sym(1);
    check("bad_v_cnt", bus.err_cnt, 1);
    for (int i = 0; i < (1 << W) + 3; i++) sym(2);
    check("sat_cnt", bus.err_cnt, CNT_MAX);
    drive(1, 1, 1, 1);
    check("clr_priority", bus.err_cnt, 0);

    // Stall cycles interleaved with a stream must not move anything
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    sym(-1);
    drive(0, 0, 1, 0);

    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit p, n;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
      end else begin
        p = $urandom_range(0, 1);
        n = $urandom_range(0, 1);
        if (p && n && $urandom_range(0, 7) != 0) p = 0;
        drive($urandom_range(0, 9) != 0, p, n, $urandom_range(0, 63) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
